// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - 2-bit FSM state encoding used by icache_line
//   - default geometry (sets, bytes per line)
//   - TRUE/FALSE single-bit constants
// ---------------------------------------------------------------------------
package icache_pkg;

   localparam int ICACHE_DEF_SETS = 64;
   localparam int ICACHE_DEF_LINE = 8;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_REFILL = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
// Byte-serial line refill engine. On start_i it latches the line number and
// walks the line: an issue counter drives mem_req_o/mem_addr_o and advances
// on each grant, a separate receive counter places each returned byte. The
// write strobe to the line storage and a one-cycle done pulse (coincident
// with the last byte write) are produced here.
//
// Ports
//   clk_i, rst_ni        clock / async active-low reset
//   rdy_i                global run enable; 0 freezes every register
//   start_i              begin refilling line line_i
//   line_i               line number (byte address without offset bits)
//   mem_gnt_i            memory accepted the current byte request
//   mem_rvalid_i         returned byte valid
//   mem_rdata_i          returned byte
//   mem_req_o            byte read request
//   mem_addr_o           byte address of mem_req_o (0 when idle)
//   wr_en_o              write wr_data_o at byte wr_off_o of the line
//   wr_off_o, wr_data_o  line write offset / data
//   done_o               last byte of the line is being written this cycle
// ---------------------------------------------------------------------------
module icache_refill
   import icache_pkg::*;
#(
   parameter int  ADDR_W     = 32,
   parameter int  LINE_BYTES = ICACHE_DEF_LINE,
   localparam int OFF_W      = $clog2(LINE_BYTES)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    rdy_i,
   input  logic                    start_i,
   input  logic [ADDR_W-OFF_W-1:0] line_i,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [7:0]              mem_rdata_i,
   output logic                    mem_req_o,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic                    wr_en_o,
   output logic [OFF_W-1:0]        wr_off_o,
   output logic [7:0]              wr_data_o,
   output logic                    done_o
);

   localparam int CNT_W = OFF_W + 1;

   logic                    active_q, active_d;
   logic [ADDR_W-OFF_W-1:0] line_q, line_d;
   logic [CNT_W-1:0]        iss_cnt_q, iss_cnt_d;
   logic [OFF_W-1:0]        rx_cnt_q, rx_cnt_d;

   // MSB of the issue counter set means every byte has been requested
   assign mem_req_o  = active_q && !iss_cnt_q[OFF_W];
   assign mem_addr_o = mem_req_o ? {line_q, iss_cnt_q[OFF_W-1:0]} : '0;

   assign wr_en_o   = active_q && rdy_i && mem_rvalid_i;
   assign wr_off_o  = rx_cnt_q;
   assign wr_data_o = mem_rdata_i;
   assign done_o    = wr_en_o && (&rx_cnt_q);

   always_comb begin
      active_d  = active_q;
      line_d    = line_q;
      iss_cnt_d = iss_cnt_q;
      rx_cnt_d  = rx_cnt_q;
      if (rdy_i) begin
         if (start_i) begin
            active_d  = TRUE;
            line_d    = line_i;
            iss_cnt_d = '0;
            rx_cnt_d  = '0;
         end else if (active_q) begin
            if (mem_req_o && mem_gnt_i) begin
               iss_cnt_d = iss_cnt_q + CNT_W'(1);
            end
            if (wr_en_o) begin
               rx_cnt_d = rx_cnt_q + OFF_W'(1);
               if (done_o) begin
                  active_d = FALSE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_q  <= FALSE;
         line_q    <= '0;
         iss_cnt_q <= '0;
         rx_cnt_q  <= '0;
      end else begin
         active_q  <= active_d;
         line_q    <= line_d;
         iss_cnt_q <= iss_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
      end
   end

endmodule

// File: rtl/icache_line.sv
// ---------------------------------------------------------------------------
// icache_line
// Direct-mapped instruction cache with multi-byte lines. Returns a 32-bit
// little-endian instruction per request; misses refill the whole line from a
// byte-serial memory port through icache_refill. Supports invalidate-all
// (flush_i) and cancellation of the outstanding request (req_cancel_i).
//
// Optional feature: define ICACHE_STATS_EN to add saturating hit/miss
// counters on stat_hits_o / stat_misses_o.
//
// Ports
//   clk_i, rst_ni    clock / async active-low reset
//   rdy_i            global run enable; 0 freezes all state
//   req_valid_i      fetch request (word-aligned req_addr_i)
//   req_addr_i       fetch byte address
//   req_ready_o      request can be accepted this cycle
//   req_cancel_i     drop the outstanding request; no response for it
//   resp_valid_o     one-cycle pulse, resp_inst_o valid
//   resp_inst_o      fetched instruction (0 when no response)
//   flush_i          invalidate every line
//   mem_req_o        byte read request
//   mem_addr_o       byte address of mem_req_o
//   mem_gnt_i        memory accepted the request
//   mem_rvalid_i     read byte valid (one cycle after grant)
//   mem_rdata_i      read byte
//   stat_hits_o      (ICACHE_STATS_EN) lookup hits
//   stat_misses_o    (ICACHE_STATS_EN) lookup misses
//
// state  | meaning
// IDLE   | ready for a request
// LOOKUP | tag/valid compare on the latched address
// REFILL | line being fetched by icache_refill
// RESP   | instruction presented for one cycle
// ---------------------------------------------------------------------------
module icache_line
   import icache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int SETS       = ICACHE_DEF_SETS,
   parameter int LINE_BYTES = ICACHE_DEF_LINE
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              rdy_i,
   input  logic              req_valid_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   output logic              req_ready_o,
   input  logic              req_cancel_i,
   output logic              resp_valid_o,
   output logic [31:0]       resp_inst_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [7:0]        mem_rdata_i
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       stat_hits_o,
   output logic [31:0]       stat_misses_o
`endif
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SETS-1:0]   valid_q, valid_d;
   logic              cancel_pend_q, cancel_pend_d;
   logic              flush_pend_q, flush_pend_d;

   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [7:0]        data_q [SETS][LINE_BYTES];

   logic [OFF_W-1:0]  off;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              hit;

   logic              refill_start;
   logic              refill_done;
   logic              wr_en;
   logic [OFF_W-1:0]  wr_off;
   logic [7:0]        wr_data;

   logic [31:0]       word;
   logic [OFF_W-1:0]  boff;

   assign off = addr_q[OFF_W-1:0];
   assign idx = addr_q[OFF_W +: IDX_W];
   assign tag = addr_q[ADDR_W-1 -: TAG_W];

   // A flush in the lookup cycle forces a miss even though the valid bits
   // only clear at the following edge.
   assign hit = valid_q[idx] && (tag_q[idx] == tag) && !flush_i;

   icache_refill #(
      .ADDR_W     (ADDR_W),
      .LINE_BYTES (LINE_BYTES)
   ) u_refill (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .rdy_i        (rdy_i),
      .start_i      (refill_start),
      .line_i       (addr_q[ADDR_W-1:OFF_W]),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .wr_en_o      (wr_en),
      .wr_off_o     (wr_off),
      .wr_data_o    (wr_data),
      .done_o       (refill_done)
   );

   // Byte offsets wrap inside the line, so the word never leaves it
   always_comb begin
      word = '0;
      boff = off;
      for (int i = 0; i < 4; i++) begin
         boff = off + OFF_W'(i);
         word[8*i +: 8] = data_q[idx][boff];
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (rdy_i) begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i && !req_cancel_i) begin
                  state_d = ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (req_cancel_i) begin
                  state_d = ST_IDLE;
               end else if (hit) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_REFILL;
               end
            end
            ST_REFILL: begin
               if (refill_done) begin
                  state_d = ST_RESP;
               end
            end
            ST_RESP: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready_o  = rst_ni && (state_q == ST_IDLE);
      resp_valid_o = (state_q == ST_RESP) && rdy_i && !req_cancel_i && !cancel_pend_q;
      resp_inst_o  = resp_valid_o ? word : '0;
      refill_start = (state_q == ST_LOOKUP) && rdy_i && !req_cancel_i && !hit;
   end

   // ---------------- datapath registers ----------------
   always_comb begin
      addr_d        = addr_q;
      valid_d       = valid_q;
      cancel_pend_d = cancel_pend_q;
      flush_pend_d  = flush_pend_q;
      if (rdy_i) begin
         if ((state_q == ST_IDLE) && req_valid_i && !req_cancel_i) begin
            addr_d = req_addr_i;
         end
         // Cancel/flush seen during a refill are remembered until the
         // refill completes; both are cleared outside REFILL.
         if (state_q == ST_REFILL) begin
            cancel_pend_d = cancel_pend_q | req_cancel_i;
            flush_pend_d  = flush_pend_q | flush_i;
         end else begin
            cancel_pend_d = FALSE;
            flush_pend_d  = FALSE;
         end
         if (flush_i) begin
            valid_d = '0;
         end else if (refill_done && !flush_pend_q) begin
            valid_d[idx] = TRUE;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q        <= '0;
         valid_q       <= '0;
         cancel_pend_q <= FALSE;
         flush_pend_q  <= FALSE;
      end else begin
         addr_q        <= addr_d;
         valid_q       <= valid_d;
         cancel_pend_q <= cancel_pend_d;
         flush_pend_q  <= flush_pend_d;
      end
   end

   // Line storage has no reset; the valid bits guard it. wr_en and
   // refill_done already carry rdy_i.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         data_q[idx][wr_off] <= wr_data;
      end
      if (refill_done) begin
         tag_q[idx] <= tag;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hits_q, hits_d;
   logic [31:0] misses_q, misses_d;

   always_comb begin
      hits_d   = hits_q;
      misses_d = misses_q;
      if (rdy_i && (state_q == ST_LOOKUP) && !req_cancel_i) begin
         if (hit) begin
            if (hits_q != '1) begin
               hits_d = hits_q + 32'd1;
            end
         end else if (misses_q != '1) begin
            misses_d = misses_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         hits_q   <= hits_d;
         misses_q <= misses_d;
      end
   end

   assign stat_hits_o   = hits_q;
   assign stat_misses_o = misses_q;
`endif

endmodule

// File: tb/tb_icache_line.sv
// ---------------------------------------------------------------------------
// tb_icache_line
// Directed bench for icache_line (default geometry, stats disabled).
// A byte memory model answers refills; expected instructions are pushed to a
// scoreboard queue at request time and popped when resp_valid is seen.
// ---------------------------------------------------------------------------
module tb_icache_line;

   logic        clk;
   logic        rst_n;
   logic        rdy;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        req_cancel;
   logic        resp_valid;
   logic [31:0] resp_inst;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [7:0]  mem_rdata;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int req_cyc = 0;
   int resp_cyc = 0;
   int resp_cnt = 0;
   int resp_base = 0;
   int gnt_cnt = 0;
   int gnt_base = 0;
   bit gnt_rand = 1'b0;

   logic [31:0] sb_q[$];
   logic [31:0] gnt_addr_q[$];
   logic [31:0] stall_addr;

   icache_line dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .rdy_i        (rdy),
      .req_valid_i  (req_valid),
      .req_addr_i   (req_addr),
      .req_ready_o  (req_ready),
      .req_cancel_i (req_cancel),
      .resp_valid_o (resp_valid),
      .resp_inst_o  (resp_inst),
      .flush_i      (flush),
      .mem_req_o    (mem_req),
      .mem_addr_o   (mem_addr),
      .mem_gnt_i    (mem_gnt),
      .mem_rvalid_i (mem_rvalid),
      .mem_rdata_i  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [7:0] m;
      m = a[7:0] * 8'd13;
      return m ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // memory: grant changes away from the edge, data one cycle after grant,
   // everything frozen while rdy is low
   initial mem_gnt = 1'b0;
   always @(posedge clk) begin
      #2;
      if (rdy) mem_gnt = mem_req && (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rvalid <= 1'b0;
         mem_rdata  <= 8'h00;
      end else if (rdy) begin
         mem_rvalid <= mem_req && mem_gnt;
         mem_rdata  <= mem_byte(mem_addr);
      end
   end

   // monitor: grants about to be taken at the next edge, and responses
   always @(negedge clk) begin
      if (rst_n && rdy && mem_req && mem_gnt) begin
         gnt_cnt++;
         gnt_addr_q.push_back(mem_addr);
      end
      if (rst_n && resp_valid) begin
         resp_cnt++;
         resp_cyc = cyc;
         chk("resp_expected", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) chk("resp_inst", resp_inst, sb_q.pop_front());
      end
   end

   task automatic issue(input logic [31:0] a, input bit expect_resp);
      int n = 0;
      @(posedge clk); #1;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_ready_wait", 32'(req_ready), 32'd1);
      gnt_addr_q.delete();
      req_valid = 1'b1;
      req_addr  = a;
      req_cyc   = cyc;
      gnt_base  = gnt_cnt;
      resp_base = resp_cnt;
      if (expect_resp) sb_q.push_back(exp_word(a));
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input int lat, input int gnts);
      int n = 0;
      while (resp_cnt == resp_base && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_resp"}, 32'(resp_cnt - resp_base), 32'd1);
      if (lat >= 0) chk({tag, "_lat"}, 32'(resp_cyc - req_cyc), 32'(lat));
      chk({tag, "_gnts"}, 32'(gnt_cnt - gnt_base), 32'(gnts));
   endtask

   task automatic wait_gnts(input string tag, input int k);
      int n = 0;
      while ((gnt_cnt - gnt_base) < k && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, 32'((gnt_cnt - gnt_base) >= k), 32'd1);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, 32'(req_ready), 32'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      rdy        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_cancel = 1'b0;
      flush      = 1'b0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_inst", resp_inst, 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_req_ready", 32'(req_ready), 32'd1);

      // cold miss: whole line fetched in order
      issue(32'h100, 1'b1);
      wait_resp("cold_0x100", -1, 8);
      chk("cold_gnt_list", 32'(gnt_addr_q.size()), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < gnt_addr_q.size()) chk($sformatf("cold_addr%0d", k), gnt_addr_q[k], 32'h100 + 32'(k));
      end

      // hit in the second word, 2-cycle latency, no memory traffic
      issue(32'h104, 1'b1);
      wait_resp("hit_0x104", 2, 0);

      // conflict on index 32 with irregular grants
      gnt_rand = 1'b1;
      issue(32'h300, 1'b1);
      wait_resp("conflict_0x300", -1, 8);
      gnt_rand = 1'b0;
      issue(32'h100, 1'b1);
      wait_resp("refetch_0x100", -1, 8);

      // cancel during refill: no response, line still installed
      issue(32'h200, 1'b0);
      wait_gnts("cancel_mid_gnts", 3);
      req_cancel = 1'b1;
      @(posedge clk); #1;
      req_cancel = 1'b0;
      wait_ready("cancel_idle");
      chk("cancel_no_resp", 32'(resp_cnt - resp_base), 32'd0);
      chk("cancel_fill_gnts", 32'(gnt_cnt - gnt_base), 32'd8);
      issue(32'h200, 1'b1);
      wait_resp("cancel_then_hit", 2, 0);

      // flush while idle
      issue(32'h100, 1'b1);
      wait_resp("pre_flush_hit", 2, 0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      issue(32'h100, 1'b1);
      wait_resp("post_flush_miss", -1, 8);

      // flush during refill: response delivered, line left invalid
      issue(32'h240, 1'b1);
      wait_gnts("flush_mid_gnts", 2);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_resp("flush_mid_fill", -1, 8);
      issue(32'h240, 1'b1);
      wait_resp("flush_mid_invalid", -1, 8);

      // stall mid-refill with grant held
      issue(32'h180, 1'b1);
      wait_gnts("stall_pre_gnts", 3);
      rdy = 1'b0;
      stall_addr = mem_addr;
      repeat (5) begin
         @(posedge clk); #1;
         chk("stall_mem_req", 32'(mem_req), 32'd1);
         chk("stall_mem_addr", mem_addr, stall_addr);
      end
      rdy = 1'b1;
      wait_resp("stall_fill", -1, 8);
      issue(32'h184, 1'b1);
      wait_resp("stall_hit", 2, 0);

      // async reset mid-refill
      issue(32'h100, 1'b1);
      wait_resp("pre_rst_fill", -1, 8);
      issue(32'h100, 1'b1);
      wait_resp("pre_rst_hit", 2, 0);
      issue(32'h140, 1'b0);
      wait_gnts("rst_pre_gnts", 3);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(32'h100, 1'b1);
      wait_resp("post_rst_0x100", -1, 8);
      issue(32'h140, 1'b1);
      wait_resp("post_rst_0x140", -1, 8);

      repeat (3) @(posedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
